// File: rtl/tetris_pkg.sv
// Shared types and constants for the active-piece move controller.
// Latency: none (types and constants only).
// Backpressure: n/a.
package tetris_pkg;

  // Default playfield geometry, walls and floor included.
  localparam int GRID_ROWS = 22;
  localparam int GRID_COLS = 12;

  // Default spawn cell of a new piece.
  localparam int DEF_SPAWN_ROW = 1;
  localparam int DEF_SPAWN_COL = 5;

  // Pointer field widths on the collision and pointer ports.
  localparam int ROW_W = 5;
  localparam int COL_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_WAIT,
    S_CHECK,
    S_COMMIT,
    S_LOCK,
    S_OVER
  } move_state_e;

  typedef enum logic [1:0] {
    KIND_SPAWN,
    KIND_DOWN,
    KIND_LEFT,
    KIND_RIGHT
  } move_kind_e;

endpackage

// File: rtl/move_req_latch.sv
// Holds pending down/left/right requests and picks the next one to service.
// Latency: a pulse becomes visible on sel_vld/sel_kind one cycle after it is sampled.
// Backpressure: none; repeat pulses merge into the pending flag, nothing is queued.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   en                      accept new pulses (low in idle / game-over)
//   grav_tick/mv_left/right request pulses
//   clr_down/left/right     drop the corresponding pending flag
//   sel_vld, sel_kind       highest-priority pending request (down > left > right)
module move_req_latch
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       grav_tick,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       clr_down,
  input  logic       clr_left,
  input  logic       clr_right,
  output logic       sel_vld,
  output move_kind_e sel_kind
);

  logic pend_down;
  logic pend_left;
  logic pend_right;
  logic lr_clash;

  // Opposite moves in the same cycle cancel each other out.
  assign lr_clash = mv_left & mv_right;

  // A fresh pulse wins over a clear in the same cycle so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_down  <= 1'b0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
    end else begin
      pend_down  <= (pend_down  & ~clr_down)  | (en & grav_tick);
      pend_left  <= (pend_left  & ~clr_left)  | (en & mv_left  & ~lr_clash);
      pend_right <= (pend_right & ~clr_right) | (en & mv_right & ~lr_clash);
    end
  end

  always_comb begin
    sel_vld  = 1'b1;
    sel_kind = KIND_DOWN;
    if (pend_down) begin
      sel_kind = KIND_DOWN;
    end else if (pend_left) begin
      sel_kind = KIND_LEFT;
    end else if (pend_right) begin
      sel_kind = KIND_RIGHT;
    end else begin
      sel_vld = 1'b0;
    end
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Sequences spawn, gravity and player moves of the active piece through the collision checker.
// Latency: request pulse to chk_req 2 cycles; chk_ack to pointer update 2 cycles.
// Backpressure: chk_req/candidate held until chk_ack; new requests wait as pending flags.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, grav_tick, mv_left/right request pulses
//   chk_req, chk_row, chk_col       candidate position sent to the collision checker
//   chk_ack, chk_blocked            checker verdict (blocked qualified by ack)
//   row_out, col_out                committed piece pointer
//   lock, newgen                    piece-lock and new-piece pulses
//   game_over, busy                 sticky end-of-game flag, sequencer activity
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS      = GRID_ROWS,
  parameter int COLS      = GRID_COLS,
  parameter int SPAWN_ROW = DEF_SPAWN_ROW,
  parameter int SPAWN_COL = DEF_SPAWN_COL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             grav_tick,
  input  logic             mv_left,
  input  logic             mv_right,
  output logic             chk_req,
  output logic [ROW_W-1:0] chk_row,
  output logic [COL_W-1:0] chk_col,
  input  logic             chk_ack,
  input  logic             chk_blocked,
  output logic [ROW_W-1:0] row_out,
  output logic [COL_W-1:0] col_out,
  output logic             lock,
  output logic             newgen,
  output logic             game_over,
  output logic             busy
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 2);  // lowest row above the floor
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 2);
  localparam logic [ROW_W-1:0] SPAWN_R  = ROW_W'(SPAWN_ROW);
  localparam logic [COL_W-1:0] SPAWN_C  = COL_W'(SPAWN_COL);

  move_state_e      state_q, state_d;
  move_kind_e       kind_q, kind_d;
  logic [ROW_W-1:0] cand_row_d, row_d;
  logic [COL_W-1:0] cand_col_d, col_d;
  logic             req_en;
  logic             clr_down, clr_left, clr_right;
  logic             sel_vld;
  move_kind_e       sel_kind;

  assign req_en = (state_q != S_IDLE) && (state_q != S_OVER);

  move_req_latch u_req_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (req_en),
    .grav_tick (grav_tick),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .clr_down  (clr_down),
    .clr_left  (clr_left),
    .clr_right (clr_right),
    .sel_vld   (sel_vld),
    .sel_kind  (sel_kind)
  );

  // State, candidate and pointer registers. Outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kind_q    <= KIND_SPAWN;
      chk_row   <= SPAWN_R;
      chk_col   <= SPAWN_C;
      row_out   <= SPAWN_R;
      col_out   <= SPAWN_C;
      chk_req   <= 1'b0;
      lock      <= 1'b0;
      newgen    <= 1'b0;
      game_over <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      chk_row   <= cand_row_d;
      chk_col   <= cand_col_d;
      row_out   <= row_d;
      col_out   <= col_d;
      chk_req   <= (state_d == S_CHECK);
      lock      <= (state_d == S_LOCK);
      newgen    <= (state_d == S_COMMIT) && (kind_d == KIND_SPAWN);
      game_over <= (state_d == S_OVER);
      busy      <= (state_d != S_IDLE) && (state_d != S_WAIT) && (state_d != S_OVER);
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cand_row_d = chk_row;
    cand_col_d = chk_col;
    row_d      = row_out;
    col_d      = col_out;
    clr_down   = 1'b0;
    clr_left   = 1'b0;
    clr_right  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SPAWN;
      end

      S_SPAWN: begin
        cand_row_d = SPAWN_R;
        cand_col_d = SPAWN_C;
        kind_d     = KIND_SPAWN;
        state_d    = S_CHECK;
      end

      // Edge limits are tested before the +/-1 so the candidate can never wrap.
      S_WAIT: begin
        if (sel_vld) begin
          unique case (sel_kind)
            KIND_DOWN: begin
              clr_down = 1'b1;
              if (row_out == ROW_LAST) begin
                state_d = S_LOCK;  // resting on the floor, no check needed
              end else begin
                cand_row_d = row_out + 5'd1;
                cand_col_d = col_out;
                kind_d     = KIND_DOWN;
                state_d    = S_CHECK;
              end
            end
            KIND_LEFT: begin
              clr_left = 1'b1;
              if (col_out != COL_MIN) begin
                cand_row_d = row_out;
                cand_col_d = col_out - 4'd1;
                kind_d     = KIND_LEFT;
                state_d    = S_CHECK;
              end
            end
            KIND_RIGHT: begin
              clr_right = 1'b1;
              if (col_out != COL_MAX) begin
                cand_row_d = row_out;
                cand_col_d = col_out + 4'd1;
                kind_d     = KIND_RIGHT;
                state_d    = S_CHECK;
              end
            end
            default: ;
          endcase
        end
      end

      S_CHECK: begin
        if (chk_ack) begin
          if (!chk_blocked) begin
            state_d = S_COMMIT;
          end else begin
            unique case (kind_q)
              KIND_DOWN:  state_d = S_LOCK;
              KIND_SPAWN: state_d = S_OVER;  // no room for a new piece
              default:    state_d = S_WAIT;  // sideways move refused
            endcase
          end
        end
      end

      S_COMMIT: begin
        row_d   = chk_row;
        col_d   = chk_col;
        state_d = S_WAIT;
      end

      // Sideways requests made for the old piece are meaningless for the next.
      S_LOCK: begin
        clr_left  = 1'b1;
        clr_right = 1'b1;
        state_d   = S_SPAWN;
      end

      S_OVER: ;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Self-checking bench for piece_move_ctrl: directed scenarios plus a random move sequence.
// Latency: n/a (testbench).
// Backpressure: the checker model acks after a random or fixed delay.
module tb_piece_move_ctrl;

  localparam int ROWS = 22;
  localparam int COLS = 12;
  localparam int SR   = 1;
  localparam int SC   = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, grav_tick, mv_left, mv_right;
  logic       chk_req, chk_ack, chk_blocked;
  logic [4:0] chk_row, row_out;
  logic [3:0] chk_col, col_out;
  logic       lock, newgen, game_over, busy;

  int  n_checks = 0;
  int  n_err    = 0;
  int  n_lock   = 0;
  int  n_newgen = 0;
  int  n_req    = 0;
  int  cyc      = 0;
  int  lock_cyc = 0;
  bit  lock_seen = 1'b0;
  bit  req_prev  = 1'b0;
  int  ack_fixed = -1;
  bit  occ [0:ROWS-1][0:COLS-1];
  int  q_row[$];
  int  q_col[$];

  piece_move_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .grav_tick   (grav_tick),
    .mv_left     (mv_left),
    .mv_right    (mv_right),
    .chk_req     (chk_req),
    .chk_row     (chk_row),
    .chk_col     (chk_col),
    .chk_ack     (chk_ack),
    .chk_blocked (chk_blocked),
    .row_out     (row_out),
    .col_out     (col_out),
    .lock        (lock),
    .newgen      (newgen),
    .game_over   (game_over),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walls, floor and the occupancy map decide whether a cell is taken.
  function automatic bit blocked(input int r, input int c);
    if (r >= ROWS - 1 || c <= 0 || c >= COLS - 1) return 1'b1;
    return occ[r][c];
  endfunction

  task automatic pulse(input bit g, input bit l, input bit r, input bit s);
    grav_tick = g; mv_left = l; mv_right = r; start = s;
    @(negedge clk);
    grav_tick = 0; mv_left = 0; mv_right = 0; start = 0;
  endtask

  // Wait until the sequencer has been idle for three cycles in a row.
  task automatic settle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (busy) quiet = 0; else quiet++;
    end
    chk({tag, "_settle"}, int'(quiet >= 3), 1);
  endtask

  task automatic clear_q();
    q_row.delete();
    q_col.delete();
  endtask

  // Collision checker model: records each request and answers after a delay.
  initial begin
    chk_ack = 0;
    chk_blocked = 0;
    forever begin
      @(negedge clk);
      if (chk_req) begin
        int r, c, d;
        r = int'(chk_row);
        c = int'(chk_col);
        q_row.push_back(r);
        q_col.push_back(c);
        d = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (chk_req) begin
            chk("req_hold_row", int'(chk_row), r);
            chk("req_hold_col", int'(chk_col), c);
          end
        end
        chk_blocked = blocked(r, c);
        chk_ack = 1;
        @(negedge clk);
        chk_ack = 0;
        chk_blocked = 0;
      end
    end
  end

  // Pulse counting, lock-to-newgen spacing and pointer range invariants.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (lock) begin
        n_lock++;
        lock_seen = 1'b1;
        lock_cyc = cyc;
      end
      if (newgen) begin
        n_newgen++;
        if (lock_seen) begin
          chk("lock_newgen_gap", int'(cyc - lock_cyc >= 3), 1);
          lock_seen = 1'b0;
        end
      end
      if (chk_req && !req_prev) n_req++;
      chk("col_range", int'(int'(col_out) >= 1 && int'(col_out) <= COLS - 2), 1);
      chk("row_range", int'(int'(row_out) <= ROWS - 2), 1);
    end else begin
      lock_seen = 1'b0;
    end
    req_prev = chk_req;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lock0, ng0, req0, n, mrow, mcol, exp_locks, sel;
    rst_n = 0; start = 0; grav_tick = 0; mv_left = 0; mv_right = 0;
    foreach (occ[r, c]) occ[r][c] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_chk_req", int'(chk_req), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_newgen", int'(newgen), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row", int'(row_out), SR);
    chk("rst_col", int'(col_out), SC);
    chk("rst_chk_row", int'(chk_row), SR);
    chk("rst_chk_col", int'(chk_col), SC);
    rst_n = 1;
    @(negedge clk);

    // Requests in IDLE are discarded
    pulse(1, 1, 0, 0);
    pulse(0, 0, 1, 0);
    repeat (4) @(negedge clk);
    chk("idle_no_req", n_req, 0);
    chk("idle_busy", int'(busy), 0);

    // 1: start and spawn
    clear_q();
    pulse(0, 0, 0, 1);
    settle("t1");
    chk("t1_newgen", n_newgen, 1);
    chk("t1_row", int'(row_out), 1);
    chk("t1_col", int'(col_out), 5);
    chk("t1_game_over", int'(game_over), 0);
    chk("t1_nchecks", q_row.size(), 1);

    // 2: walk to the left wall
    for (int i = 0; i < 4; i++) begin
      pulse(0, 1, 0, 0);
      settle("t2");
      chk("t2_col", int'(col_out), 4 - i);
    end
    clear_q();
    pulse(0, 1, 0, 0);
    settle("t2_wall");
    chk("t2_wall_nchecks", q_row.size(), 0);
    chk("t2_wall_col", int'(col_out), 1);

    for (int i = 0; i < 4; i++) begin
      pulse(0, 0, 1, 0);
      settle("back");
    end
    chk("back_col", int'(col_out), 5);

    // 3: fall to row 7, then blocked fall locks and respawns
    for (int i = 0; i < 6; i++) begin
      pulse(1, 0, 0, 0);
      settle("t3_fall");
    end
    chk("t3_row7", int'(row_out), 7);
    occ[8][5] = 1'b1;
    lock0 = n_lock; ng0 = n_newgen;
    clear_q();
    pulse(1, 0, 0, 0);
    settle("t3");
    chk("t3_lock", n_lock - lock0, 1);
    chk("t3_newgen", n_newgen - ng0, 1);
    chk("t3_row", int'(row_out), 1);
    chk("t3_col", int'(col_out), 5);
    chk("t3_nchecks", q_row.size(), 2);
    if (q_row.size() >= 2) begin
      chk("t3_down_row", q_row[0], 8);
      chk("t3_spawn_row", q_row[1], 1);
      chk("t3_spawn_col", q_col[1], 5);
    end
    occ[8][5] = 1'b0;

    // 4: down and right in the same cycle
    pulse(1, 0, 0, 0); settle("t4_fall");
    pulse(1, 0, 0, 0); settle("t4_fall");
    chk("t4_row3", int'(row_out), 3);
    clear_q();
    pulse(1, 0, 1, 0);
    settle("t4");
    chk("t4_nchecks", q_row.size(), 2);
    if (q_row.size() >= 2) begin
      chk("t4_first_row", q_row[0], 4);
      chk("t4_first_col", q_col[0], 5);
      chk("t4_second_row", q_row[1], 4);
      chk("t4_second_col", q_col[1], 6);
    end
    chk("t4_row", int'(row_out), 4);
    chk("t4_col", int'(col_out), 6);

    // 5: floor lock, blocked spawn, game over
    pulse(0, 1, 0, 0); settle("t5_left");
    for (int i = 0; i < 16; i++) begin
      pulse(1, 0, 0, 0);
      settle("t5_fall");
    end
    chk("t5_row20", int'(row_out), 20);
    chk("t5_col5", int'(col_out), 5);
    occ[1][5] = 1'b1;
    lock0 = n_lock; ng0 = n_newgen;
    clear_q();
    pulse(1, 0, 0, 0);
    settle("t5");
    chk("t5_nchecks", q_row.size(), 1);
    if (q_row.size() >= 1) begin
      chk("t5_spawn_row", q_row[0], 1);
      chk("t5_spawn_col", q_col[0], 5);
    end
    chk("t5_lock", n_lock - lock0, 1);
    chk("t5_newgen", n_newgen - ng0, 0);
    chk("t5_game_over", int'(game_over), 1);
    req0 = n_req;
    pulse(1, 1, 0, 0);
    pulse(0, 0, 1, 1);
    repeat (10) @(negedge clk);
    chk("t5_ignored_req", n_req - req0, 0);
    chk("t5_still_over", int'(game_over), 1);
    chk("t5_over_busy", int'(busy), 0);
    chk("t5_over_row", int'(row_out), 20);
    occ[1][5] = 1'b0;

    // 6: reset during a held request, late ack ignored
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_over_cleared", int'(game_over), 0);
    pulse(0, 0, 0, 1);
    settle("t6_start");
    ack_fixed = 10;
    pulse(1, 0, 0, 0);
    n = 0;
    while (!chk_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_req_seen", int'(chk_req), 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_req_dropped", int'(chk_req), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_row", int'(row_out), 1);
    chk("t6_col", int'(col_out), 5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    req0 = n_req;
    repeat (15) @(negedge clk);
    chk("t6_no_req_after", n_req - req0, 0);
    chk("t6_idle_busy", int'(busy), 0);
    chk("t6_idle_row", int'(row_out), 1);
    chk("t6_idle_col", int'(col_out), 5);
    chk("t6_idle_over", int'(game_over), 0);
    ack_fixed = -1;

    // Random moves against a scattered field
    for (int k = 0; k < 40; k++) begin
      occ[$urandom_range(2, ROWS - 2)][$urandom_range(1, COLS - 2)] = 1'b1;
    end
    pulse(0, 0, 0, 1);
    settle("rnd_start");
    mrow = SR; mcol = SC; exp_locks = 0; lock0 = n_lock;
    for (int k = 0; k < 150; k++) begin
      sel = int'($urandom_range(0, 7));
      if (sel < 3) begin
        pulse(1, 0, 0, 0);
        if (mrow == ROWS - 2 || blocked(mrow + 1, mcol)) begin
          exp_locks++;
          mrow = SR;
          mcol = SC;
        end else begin
          mrow++;
        end
      end else if (sel < 5) begin
        pulse(0, 1, 0, 0);
        if (mcol > 1 && !blocked(mrow, mcol - 1)) mcol--;
      end else if (sel < 7) begin
        pulse(0, 0, 1, 0);
        if (mcol < COLS - 2 && !blocked(mrow, mcol + 1)) mcol++;
      end else begin
        pulse(0, 1, 1, 0);
      end
      settle("rnd");
      chk("rnd_row", int'(row_out), mrow);
      chk("rnd_col", int'(col_out), mcol);
    end
    chk("rnd_locks", n_lock - lock0, exp_locks);
    chk("rnd_game_over", int'(game_over), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
